// File: rtl/router_pkg.sv
// Shared router constants: datapath widths and the reserved header address.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'b11;

  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/router_reg_if.sv
// Bus between the router controller/source and the router register block.
// master drives the source byte, FIFO status and state decodes; slave
// (router_reg) returns the output byte and packet status.
interface router_reg_if;
  import router_pkg::*;

  logic        pkt_valid;
  byte_t       data_in;
  logic        fifo_full;
  logic        detect_add;
  logic        lfd_state;
  logic        ld_state;
  logic        laf_state;
  logic        full_state;
  logic        rst_int_reg;
  byte_t       dout;
  logic        parity_done;
  logic        low_packet_valid;
  logic        err;
  logic [7:0]  err_count;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err, err_count
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err, err_count
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity of the bytes of one packet.
module router_parity_acc
  import router_pkg::*;
(
  input  logic  clock,
  input  logic  resetn,
  input  logic  clr,
  input  logic  xor_en,
  input  byte_t xor_data,
  output byte_t parity
);

  // clear at packet start, otherwise fold in each enabled byte
  always_ff @(posedge clock) begin
    if (!resetn)
      parity <= '0;
    else if (clr)
      parity <= '0;
    else if (xor_en)
      parity <= parity ^ xor_data;
  end

endmodule

// File: rtl/router_reg.sv
// Router register block: header/hold byte capture, output byte mux,
// parity check and error reporting.
// Optional build macro ROUTER_REG_ERR_COUNT_EN enables the saturating
// errored-packet counter; without it err_count reads 8'h00.
module router_reg
  import router_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  router_reg_if.slave  bus
);

  byte_t header_byte;
  byte_t hold_byte;
  byte_t pkt_parity;
  byte_t int_parity;
  byte_t dout_q;
  logic  hold_is_parity;
  logic  parity_done_q;
  logic  parity_done_d;
  logic  low_pv_q;
  logic  err_q;
  logic  err_next;
  logic  err_eval;
  logic  [7:0] err_count_q;

  logic  upd;
  logic  det_s, lfd_s, ld_s, laf_s;
  logic  acc_en;
  byte_t acc_data;
  logic  par_cap;
  byte_t par_cap_data;

  // state decode with fixed priority; full_state freezes every register
  always_comb begin
    upd   = !bus.full_state;
    det_s = upd && bus.detect_add;
    lfd_s = upd && !bus.detect_add && bus.lfd_state;
    ld_s  = upd && !bus.detect_add && !bus.lfd_state && bus.ld_state;
    laf_s = upd && !bus.detect_add && !bus.lfd_state && !bus.ld_state && bus.laf_state;
  end

  // select which byte, if any, feeds the parity accumulator this cycle
  always_comb begin
    acc_en   = 1'b0;
    acc_data = '0;
    if (lfd_s) begin
      acc_en   = 1'b1;
      acc_data = header_byte;
    end else if (ld_s && bus.pkt_valid && !bus.fifo_full) begin
      acc_en   = 1'b1;
      acc_data = bus.data_in;
    end else if (laf_s && !hold_is_parity) begin
      acc_en   = 1'b1;
      acc_data = hold_byte;
    end
  end

  // the parity byte arrives either directly or via the hold register
  always_comb begin
    par_cap      = 1'b0;
    par_cap_data = '0;
    if (ld_s && !bus.pkt_valid && !bus.fifo_full) begin
      par_cap      = 1'b1;
      par_cap_data = bus.data_in;
    end else if (laf_s && hold_is_parity) begin
      par_cap      = 1'b1;
      par_cap_data = hold_byte;
    end
  end

  // compare once, on the first cycle parity_done is seen high
  always_comb begin
    err_eval = upd && parity_done_q && !parity_done_d;
    err_next = err_q;
    if (det_s)
      err_next = 1'b0;
    else if (err_eval)
      err_next = (int_parity != pkt_parity);
  end

  router_parity_acc u_parity_acc (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (det_s),
    .xor_en   (acc_en),
    .xor_data (acc_data),
    .parity   (int_parity)
  );

  // header, hold and output byte datapath
  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte    <= '0;
      hold_byte      <= '0;
      hold_is_parity <= 1'b0;
      dout_q         <= '0;
    end else begin
      if (det_s && bus.pkt_valid && (bus.data_in[ADDR_W-1:0] != ADDR_RSVD))
        header_byte <= bus.data_in;
      if (ld_s && bus.fifo_full) begin
        hold_byte      <= bus.data_in;
        hold_is_parity <= !bus.pkt_valid;
      end
      if (lfd_s)
        dout_q <= header_byte;
      else if (ld_s && !bus.fifo_full)
        dout_q <= bus.data_in;
      else if (laf_s)
        dout_q <= hold_byte;
    end
  end

  // packet status flags
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pkt_parity    <= '0;
      parity_done_q <= 1'b0;
      parity_done_d <= 1'b0;
      low_pv_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (par_cap)
        pkt_parity <= par_cap_data;
      if (det_s)
        parity_done_q <= 1'b0;
      else if (par_cap)
        parity_done_q <= 1'b1;
      if (upd)
        parity_done_d <= parity_done_q;
      if (upd && bus.rst_int_reg)
        low_pv_q <= 1'b0;
      else if (ld_s && !bus.pkt_valid)
        low_pv_q <= 1'b1;
      err_q <= err_next;
    end
  end

`ifdef ROUTER_REG_ERR_COUNT_EN
  // count err rising edges, saturating
  always_ff @(posedge clock) begin
    if (!resetn)
      err_count_q <= '0;
    else if (err_next && !err_q && (err_count_q != 8'hFF))
      err_count_q <= err_count_q + 8'd1;
  end
`else
  // counter not built
  always_comb err_count_q = 8'h00;
`endif

  // drive the bus outputs
  always_comb begin
    bus.dout             = dout_q;
    bus.parity_done      = parity_done_q;
    bus.low_packet_valid = low_pv_q;
    bus.err              = err_q;
    bus.err_count        = err_count_q;
  end

endmodule

// File: tb/tb_router_reg.sv
// Directed self-checking bench for router_reg.
module tb_router_reg;
  import router_pkg::*;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DET  = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RST  = 6'b000001;

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_cnt;

  router_reg_if bus ();

  router_reg dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
    {bus.detect_add, bus.lfd_state, bus.ld_state,
     bus.laf_state, bus.full_state, bus.rst_int_reg} = st;
    bus.pkt_valid = pv;
    bus.data_in   = d;
    bus.fifo_full = ff;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
    resetn = 1'b1;
    exp_cnt = 8'h00;
  endtask

  // header, one payload byte, parity byte, then one idle cycle for err
  task automatic run_pkt(input logic [7:0] hdr, input logic [7:0] pay, input logic [7:0] par);
    drive(S_DET, 1'b1, hdr, 1'b0);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    drive(S_LD,  1'b1, pay, 1'b0);
    drive(S_LD,  1'b0, par, 1'b0);
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 8'h00;
    resetn   = 1'b0;
    drive(S_IDLE, 1'b0, 8'hFF, 1'b0);
    drive(S_IDLE, 1'b0, 8'hFF, 1'b0);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_pdone", {7'd0, bus.parity_done}, 8'h00);
    check("rst_lpv", {7'd0, bus.low_packet_valid}, 8'h00);
    check("rst_err", {7'd0, bus.err}, 8'h00);
    check("rst_cnt", bus.err_count, 8'h00);
    resetn = 1'b1;

    // clean packet 05, A3, A6
    drive(S_DET, 1'b1, 8'h05, 1'b0);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    check("clean_hdr", bus.dout, 8'h05);
    drive(S_LD, 1'b1, 8'hA3, 1'b0);
    check("clean_pay", bus.dout, 8'hA3);
    drive(S_LD, 1'b0, 8'hA6, 1'b0);
    check("clean_par", bus.dout, 8'hA6);
    check("clean_pdone", {7'd0, bus.parity_done}, 8'h01);
    check("clean_lpv", {7'd0, bus.low_packet_valid}, 8'h01);
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
    check("clean_err", {7'd0, bus.err}, 8'h00);
    check("clean_cnt", bus.err_count, exp_cnt);
    drive(S_RST, 1'b0, 8'h00, 1'b0);
    check("clean_lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);

    // corrupt parity byte
    drive(S_DET, 1'b1, 8'h05, 1'b0);
    check("bad_pdone_clr", {7'd0, bus.parity_done}, 8'h00);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    drive(S_LD, 1'b1, 8'hA3, 1'b0);
    drive(S_LD, 1'b0, 8'hA7, 1'b0);
    check("bad_pdone", {7'd0, bus.parity_done}, 8'h01);
    check("bad_err_early", {7'd0, bus.err}, 8'h00);
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
`ifdef ROUTER_REG_ERR_COUNT_EN
    exp_cnt = exp_cnt + 8'd1;
`endif
    check("bad_err", {7'd0, bus.err}, 8'h01);
    check("bad_cnt", bus.err_count, exp_cnt);
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
    check("bad_err_hold", {7'd0, bus.err}, 8'h01);

    // fifo full mid-payload: 05, 3C held, parity 05^3C=39
    drive(S_DET, 1'b1, 8'h05, 1'b0);
    check("full_err_clr", {7'd0, bus.err}, 8'h00);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    drive(S_LD, 1'b1, 8'h3C, 1'b1);
    check("full_dout_hold", bus.dout, 8'h05);
    drive(S_FULL, 1'b1, 8'h99, 1'b1);
    check("full_state_hold", bus.dout, 8'h05);
    drive(S_LAF, 1'b1, 8'h00, 1'b0);
    check("full_laf_dout", bus.dout, 8'h3C);
    drive(S_LD, 1'b0, 8'h39, 1'b0);
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
    check("full_pdone", {7'd0, bus.parity_done}, 8'h01);
    check("full_err", {7'd0, bus.err}, 8'h00);
    drive(S_RST, 1'b0, 8'h00, 1'b0);

    // fifo full on the parity byte: 05, A3, A6 held
    drive(S_DET, 1'b1, 8'h05, 1'b0);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    drive(S_LD, 1'b1, 8'hA3, 1'b0);
    drive(S_LD, 1'b0, 8'hA6, 1'b1);
    check("fpar_dout_hold", bus.dout, 8'hA3);
    check("fpar_pdone_wait", {7'd0, bus.parity_done}, 8'h00);
    check("fpar_lpv", {7'd0, bus.low_packet_valid}, 8'h01);
    drive(S_LAF, 1'b0, 8'h00, 1'b0);
    check("fpar_laf_dout", bus.dout, 8'hA6);
    check("fpar_pdone", {7'd0, bus.parity_done}, 8'h01);
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
    check("fpar_err", {7'd0, bus.err}, 8'h00);
    check("fpar_lpv_hold", {7'd0, bus.low_packet_valid}, 8'h01);
    drive(S_RST, 1'b0, 8'h00, 1'b0);
    check("fpar_lpv_clr", {7'd0, bus.low_packet_valid}, 8'h00);

    // reserved address leaves header_byte at 05
    drive(S_DET, 1'b1, 8'h07, 1'b0);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    check("rsvd_hdr", bus.dout, 8'h05);
    // new valid header replaces it
    drive(S_DET, 1'b1, 8'h2A, 1'b0);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    check("new_hdr", bus.dout, 8'h2A);

    // reset in the middle of a packet
    drive(S_DET, 1'b1, 8'h05, 1'b0);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    drive(S_LD, 1'b1, 8'hA3, 1'b0);
    drive(S_LD, 1'b0, 8'hA7, 1'b0);
    drive(S_IDLE, 1'b0, 8'h00, 1'b0);
    resetn = 1'b0;
    drive(S_LD, 1'b1, 8'h55, 1'b0);
    resetn = 1'b1;
    exp_cnt = 8'h00;
    check("mid_rst_dout", bus.dout, 8'h00);
    check("mid_rst_pdone", {7'd0, bus.parity_done}, 8'h00);
    check("mid_rst_lpv", {7'd0, bus.low_packet_valid}, 8'h00);
    check("mid_rst_err", {7'd0, bus.err}, 8'h00);
    check("mid_rst_cnt", bus.err_count, 8'h00);
    drive(S_LFD, 1'b1, 8'h00, 1'b0);
    check("mid_rst_hdr", bus.dout, 8'h00);

    // 256 errored packets: counter saturates (or stays 0 when not built)
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_pkt(8'h05, 8'hA3, 8'hA7);
`ifdef ROUTER_REG_ERR_COUNT_EN
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
      if (i % 32 == 0 || i >= 253) begin
        check("sat_err", {7'd0, bus.err}, 8'h01);
        check("sat_cnt", bus.err_count, exp_cnt);
      end
    end
`ifdef ROUTER_REG_ERR_COUNT_EN
    check("sat_final", bus.err_count, 8'hFF);
`else
    check("sat_final", bus.err_count, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
